absorb_fsm: RTL

ABSORB_FSM -- requirements
Module: absorb_fsm

---
 rtl/absorb_fsm.sv | 138 +++++++++++++
 1 files changed

// File: rtl/absorb_fsm.sv
// Control sequencer for a Keccak sponge: absorbs padded blocks, runs NUM_ROUNDS
// rounds per permutation and hands rate blocks to the output stage when squeezing.
module absorb_fsm #(
    parameter int NUM_ROUNDS = 24,
    parameter int ROUND_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               input_buffer_ready_wr,
    input  logic               last_block_in_buffer_wr,
    output logic               input_buffer_ready,
    output logic               state_reset,
    output logic               absorb_enable,
    output logic               round_enable,
    output logic [ROUND_W-1:0] round_index,
    input  logic               output_buffer_busy,
    input  logic               last_output_block,
    output logic               output_buffer_wr,
    output logic               output_last,
    output logic [2:0]         fsm_state
);

    typedef enum logic [2:0] {
        S_RESET        = 3'd0,
        S_WAIT_BLOCK   = 3'd1,
        S_ABSORB       = 3'd2,
        S_PERMUTE      = 3'd3,
        S_SQUEEZE_WAIT = 3'd4
    } state_t;

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

    state_t             state_q, state_d;
    logic               ibr_q;
    logic               last_q;
    logic               absorb_last_q;
    logic [ROUND_W-1:0] round_q;
    logic               squeeze_done;

    assign input_buffer_ready = ibr_q;
    assign fsm_state          = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // last_q belongs to the block waiting in the buffer; absorb_last_q to the
    // message currently being permuted, so a new write cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ibr_q         <= 1'b0;
            last_q        <= 1'b0;
            absorb_last_q <= 1'b0;
            round_q       <= '0;
        end else begin
            if (input_buffer_ready_wr) begin
                ibr_q  <= 1'b1;
                last_q <= last_block_in_buffer_wr;
            end else if (state_q == S_ABSORB) begin
                ibr_q <= 1'b0;
            end

            if (state_q == S_ABSORB) begin
                absorb_last_q <= last_q;
            end else if (squeeze_done) begin
                absorb_last_q <= 1'b0;
            end

            if (state_q == S_ABSORB) begin
                round_q <= '0;
            end else if (state_q == S_PERMUTE) begin
                round_q <= (round_q == LAST_ROUND) ? '0 : round_q + ROUND_W'(1);
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        state_reset      = 1'b0;
        absorb_enable    = 1'b0;
        round_enable     = 1'b0;
        round_index      = '0;
        output_buffer_wr = 1'b0;
        output_last      = 1'b0;
        squeeze_done     = 1'b0;

        case (state_q)
            S_RESET: begin
                state_reset = 1'b1;
                state_d     = S_WAIT_BLOCK;
            end
            S_WAIT_BLOCK: begin
                if (ibr_q) state_d = S_ABSORB;
            end
            S_ABSORB: begin
                absorb_enable = 1'b1;
                state_d       = S_PERMUTE;
            end
            S_PERMUTE: begin
                round_enable = 1'b1;
                round_index  = round_q;
                if (round_q == LAST_ROUND) begin
                    state_d = absorb_last_q ? S_SQUEEZE_WAIT : S_WAIT_BLOCK;
                end
            end
            S_SQUEEZE_WAIT: begin
                // Copy pulse is Mealy so the block leaves the moment the output stage frees up.
                if (!output_buffer_busy) begin
                    output_buffer_wr = 1'b1;
                    if (last_output_block) begin
                        output_last  = 1'b1;
                        state_reset  = 1'b1;
                        squeeze_done = 1'b1;
                        state_d      = S_WAIT_BLOCK;
                    end else begin
                        state_d = S_PERMUTE;
                    end
                end
            end
            default: state_d = S_RESET;
        endcase

        if (rst) begin
            state_reset      = 1'b0;
            absorb_enable    = 1'b0;
            round_enable     = 1'b0;
            round_index      = '0;
            output_buffer_wr = 1'b0;
            output_last      = 1'b0;
            squeeze_done     = 1'b0;
        end
    end

endmodule
